// File: rtl/zeroheti_pkg.sv
// Shared types and defaults for the zeroheti APB->OBI bridge.
package zeroheti_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } apb2obi_state_e;

    localparam int unsigned ApbObiTimeoutDefault = 255;

endpackage

// File: rtl/zeroheti_apb2obi_timeout.sv
// Saturating response-wait counter for the APB->OBI bridge.
// Only instantiated when ZEROHETI_APB2OBI_TIMEOUT_EN is defined.
module zeroheti_apb2obi_timeout
    import zeroheti_pkg::*;
#(
    parameter int unsigned TimeoutCycles = ApbObiTimeoutDefault
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    // Expiry fires during the TimeoutCycles-th enabled cycle so the owner
    // leaves its wait state exactly TimeoutCycles cycles after entering it.
    localparam logic [CntWidth-1:0] Limit = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == Limit);

endmodule

// File: rtl/zeroheti_apb_to_obi.sv
// APB4 completer -> OBI manager bridge, one transfer in flight at a time.
// Optional response timeout with drain tracking: ZEROHETI_APB2OBI_TIMEOUT_EN.
module zeroheti_apb_to_obi
    import zeroheti_pkg::*;
#(
    parameter  int unsigned AddrWidth     = 32,
    parameter  int unsigned DataWidth     = 32,
    parameter  int unsigned TimeoutCycles = ApbObiTimeoutDefault,
    localparam int unsigned StrbWidth     = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 apb_psel_i,
    input  logic                 apb_penable_i,
    input  logic                 apb_pwrite_i,
    input  logic [AddrWidth-1:0] apb_paddr_i,
    input  logic [DataWidth-1:0] apb_pwdata_i,
    input  logic [StrbWidth-1:0] apb_pstrb_i,
    input  logic [2:0]           apb_pprot_i,
    output logic [DataWidth-1:0] apb_prdata_o,
    output logic                 apb_pready_o,
    output logic                 apb_pslverr_o,
    output logic                 obi_req_o,
    input  logic                 obi_gnt_i,
    output logic [AddrWidth-1:0] obi_addr_o,
    output logic                 obi_we_o,
    output logic [StrbWidth-1:0] obi_be_o,
    output logic [DataWidth-1:0] obi_wdata_o,
    input  logic                 obi_rvalid_i,
    input  logic [DataWidth-1:0] obi_rdata_i,
    input  logic                 obi_err_i
);

    apb2obi_state_e       state_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 we_q;
    logic [StrbWidth-1:0] be_q;
    logic [DataWidth-1:0] wdata_q;
    logic [DataWidth-1:0] prdata_q;
    logic                 pslverr_q;
    logic                 abort_q;
    logic                 setup;

    assign setup = apb_psel_i && !apb_penable_i;

`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
    logic drain_q;
    logic pend_q;
    logic tmo_expired;

    zeroheti_apb2obi_timeout #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q != RESP),
        .en_i     (state_q == RESP),
        .expired_o(tmo_expired)
    );

    logic unused_cfg;
    assign unused_cfg = ^{apb_pprot_i, apb_paddr_i[1:0]};
`else
    logic unused_cfg;
    assign unused_cfg = ^{apb_pprot_i, apb_paddr_i[1:0], TimeoutCycles[0]};
`endif

    // NOTE: clocked state uses non-blocking assignments only, and the async
    // reset clears the datapath latches too, so every output reads 0 in reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            abort_q   <= 1'b0;
`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
            drain_q   <= 1'b0;
            pend_q    <= 1'b0;
`endif
        end else begin
            // An initiator that drops psel mid-transfer abandons it; the OBI
            // side still has to finish, but the response is thrown away.
            if ((state_q == REQ || state_q == RESP) && !apb_psel_i) begin
                abort_q <= 1'b1;
            end
`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
            if (obi_rvalid_i) begin
                drain_q <= 1'b0;
            end
`endif
            unique case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (setup) begin
                        addr_q  <= {apb_paddr_i[AddrWidth-1:2], 2'b00};
                        we_q    <= apb_pwrite_i;
                        be_q    <= apb_pwrite_i ? apb_pstrb_i : '1;
                        wdata_q <= apb_pwrite_i ? apb_pwdata_i : '0;
                    end
`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
                    // While a timed-out response is still owed, hold the new
                    // transfer pending until that late rvalid has drained.
                    if (drain_q) begin
                        if (setup) begin
                            pend_q <= 1'b1;
                        end else if (!apb_psel_i) begin
                            pend_q <= 1'b0;
                        end
                    end else if (setup || (pend_q && apb_psel_i)) begin
                        pend_q  <= 1'b0;
                        state_q <= REQ;
                    end else begin
                        pend_q <= 1'b0;
                    end
`else
                    if (setup) begin
                        state_q <= REQ;
                    end
`endif
                end
                REQ: begin
                    if (obi_gnt_i) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (obi_rvalid_i) begin
                        if (abort_q || !apb_psel_i) begin
                            state_q <= IDLE;
                        end else begin
                            prdata_q  <= (we_q || obi_err_i) ? '0 : obi_rdata_i;
                            pslverr_q <= obi_err_i;
                            state_q   <= DONE;
                        end
                    end
`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
                    else if (tmo_expired) begin
                        prdata_q  <= '0;
                        pslverr_q <= 1'b1;
                        drain_q   <= 1'b1;
                        state_q   <= DONE;
                    end
`endif
                end
                DONE: begin
                    if (!apb_psel_i || apb_penable_i) begin
                        prdata_q  <= '0;
                        pslverr_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign obi_req_o     = (state_q == REQ);
    assign obi_addr_o    = addr_q;
    assign obi_we_o      = we_q;
    assign obi_be_o      = be_q;
    assign obi_wdata_o   = wdata_q;
    assign apb_pready_o  = (state_q == DONE);
    assign apb_prdata_o  = prdata_q;
    assign apb_pslverr_o = pslverr_q;

endmodule

// File: tb/tb_zeroheti_apb_to_obi.sv
// Directed self-checking bench for zeroheti_apb_to_obi with a response scoreboard.
module tb_zeroheti_apb_to_obi;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        apb_psel_i, apb_penable_i, apb_pwrite_i;
    logic [31:0] apb_paddr_i, apb_pwdata_i;
    logic [3:0]  apb_pstrb_i;
    logic [2:0]  apb_pprot_i;
    logic [31:0] apb_prdata_o;
    logic        apb_pready_o, apb_pslverr_o;
    logic        obi_req_o, obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    always #5 clk_i = ~clk_i;

    zeroheti_apb_to_obi dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .apb_psel_i   (apb_psel_i),
        .apb_penable_i(apb_penable_i),
        .apb_pwrite_i (apb_pwrite_i),
        .apb_paddr_i  (apb_paddr_i),
        .apb_pwdata_i (apb_pwdata_i),
        .apb_pstrb_i  (apb_pstrb_i),
        .apb_pprot_i  (apb_pprot_i),
        .apb_prdata_o (apb_prdata_o),
        .apb_pready_o (apb_pready_o),
        .apb_pslverr_o(apb_pslverr_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
        .obi_err_i    (obi_err_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, inout int lat);
        int budget;
        budget = 0;
        while (apb_pready_o !== 1'b1 && budget < 400) begin
            @(negedge clk_i);
            lat++;
            budget++;
        end
        check({tag, ".pready"}, 64'(apb_pready_o), 64'd1);
    endtask

    task automatic compare_response(input string tag);
        resp_t exp;
        if (sb.size() == 0) begin
            check({tag, ".sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, ".prdata"}, 64'(apb_prdata_o), 64'(exp.rdata));
            check({tag, ".pslverr"}, 64'(apb_pslverr_o), 64'(exp.err));
        end
    endtask

    // One complete APB transfer with an OBI subordinate that grants after
    // gnt_dly idle request cycles and responds rv_dly cycles after the grant.
    task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input logic err);
        resp_t       exp;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        int          lat;
        exp_addr  = {addr[31:2], 2'b00};
        exp_be    = wr ? strb : 4'hF;
        exp.rdata = (wr || err) ? 32'h0 : rdata;
        exp.err   = err;
        sb.push_back(exp);

        @(negedge clk_i);
        apb_psel_i = 1'b1; apb_penable_i = 1'b0; apb_pwrite_i = wr;
        apb_paddr_i = addr; apb_pwdata_i = wdata; apb_pstrb_i = strb;
        lat = 0;
        @(negedge clk_i);
        lat++;
        apb_penable_i = 1'b1;
        check({name, ".req"}, 64'(obi_req_o), 64'd1);
        check({name, ".addr"}, 64'(obi_addr_o), 64'(exp_addr));
        check({name, ".be"}, 64'(obi_be_o), 64'(exp_be));
        check({name, ".we"}, 64'(obi_we_o), 64'(wr));
        if (wr) check({name, ".wdata"}, 64'(obi_wdata_o), 64'(wdata));
        for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk_i);
            lat++;
            check({name, ".req_held"}, 64'(obi_req_o), 64'd1);
            check({name, ".addr_stable"}, 64'(obi_addr_o), 64'(exp_addr));
        end
        obi_gnt_i = 1'b1;
        @(negedge clk_i);
        lat++;
        obi_gnt_i = 1'b0;
        check({name, ".req_drop"}, 64'(obi_req_o), 64'd0);
        for (int i = 1; i < rv_dly; i++) begin
            @(negedge clk_i);
            lat++;
            check({name, ".no_early_ready"}, 64'(apb_pready_o), 64'd0);
        end
        obi_rvalid_i = 1'b1; obi_rdata_i = rdata; obi_err_i = err;
        @(negedge clk_i);
        lat++;
        obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0; obi_err_i = 1'b0;
        wait_ready(name, lat);
        check({name, ".latency"}, 64'(lat), 64'(3 + gnt_dly + rv_dly - 1));
        compare_response(name);
        @(negedge clk_i);
        apb_psel_i = 1'b0; apb_penable_i = 1'b0;
        check({name, ".ready_clear"}, 64'(apb_pready_o), 64'd0);
    endtask

    initial begin
        int lat;
        rst_i = 1'b1;
        apb_psel_i = 1'b0; apb_penable_i = 1'b0; apb_pwrite_i = 1'b0;
        apb_paddr_i = '0; apb_pwdata_i = '0; apb_pstrb_i = '0; apb_pprot_i = 3'b010;
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset.req", 64'(obi_req_o), 64'd0);
        check("reset.pready", 64'(apb_pready_o), 64'd0);
        check("reset.pslverr", 64'(apb_pslverr_o), 64'd0);
        check("reset.prdata", 64'(apb_prdata_o), 64'd0);
        check("reset.obi_bus", 64'({obi_addr_o, obi_we_o, obi_be_o}), 64'd0);
        check("reset.wdata", 64'(obi_wdata_o), 64'd0);
        rst_i = 1'b0;

        xfer("t1_write", 1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'hAAAA_5555, 1'b0);
        xfer("t2_read", 1'b0, 32'h0001_0004, 32'h0, 4'h0, 3, 2, 32'hDEAD_BEEF, 1'b0);
        xfer("t3_unaligned", 1'b0, 32'h0000_0007, 32'h0, 4'h2, 0, 1, 32'h0BAD_F00D, 1'b0);
        xfer("t4_err", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, 1, 32'h0000_1234, 1'b1);
        xfer("t4b_write_strb", 1'b1, 32'h0000_0022, 32'h1122_3344, 4'h5, 0, 3, 32'h0, 1'b0);

        // Abandoned transfer: psel drops in RESP, a setup appears while still in RESP.
        @(negedge clk_i);
        apb_psel_i = 1'b1; apb_penable_i = 1'b0; apb_pwrite_i = 1'b0; apb_paddr_i = 32'h100;
        @(negedge clk_i);
        apb_penable_i = 1'b1; obi_gnt_i = 1'b1;
        @(negedge clk_i);
        obi_gnt_i = 1'b0; apb_psel_i = 1'b0; apb_penable_i = 1'b0;
        check("t5.req_drop", 64'(obi_req_o), 64'd0);
        @(negedge clk_i);
        apb_psel_i = 1'b1; apb_paddr_i = 32'h200;
        @(negedge clk_i);
        check("t5.no_latch_outside_idle", 64'(obi_addr_o), 64'h100);
        check("t5.no_ready_abandoned", 64'(apb_pready_o), 64'd0);
        apb_penable_i = 1'b1; obi_rvalid_i = 1'b1; obi_rdata_i = 32'h5555_5555;
        @(negedge clk_i);
        obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0;
        check("t5.discarded_no_ready", 64'(apb_pready_o), 64'd0);
        apb_psel_i = 1'b0; apb_penable_i = 1'b0;
        @(negedge clk_i);
        check("t5.idle_no_req", 64'(obi_req_o), 64'd0);
        check("t5.idle_no_ready", 64'(apb_pready_o), 64'd0);
        xfer("t5_second", 1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 1, 32'h600D_0200, 1'b0);

        // Reset asserted while in REQ, then a stray rvalid.
        @(negedge clk_i);
        apb_psel_i = 1'b1; apb_penable_i = 1'b0; apb_pwrite_i = 1'b1;
        apb_paddr_i = 32'h300; apb_pwdata_i = 32'hCAFE_0300; apb_pstrb_i = 4'hF;
        @(negedge clk_i);
        apb_penable_i = 1'b1;
        check("rst.req_before", 64'(obi_req_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        check("rst.req_async", 64'(obi_req_o), 64'd0);
        check("rst.addr_async", 64'(obi_addr_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0; apb_psel_i = 1'b0; apb_penable_i = 1'b0;
        @(negedge clk_i);
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk_i);
        obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0;
        check("rst.stray_no_ready", 64'(apb_pready_o), 64'd0);
        check("rst.stray_no_req", 64'(obi_req_o), 64'd0);
        check("rst.stray_prdata", 64'(apb_prdata_o), 64'd0);
        xfer("rst_recover", 1'b0, 32'h0000_0308, 32'h0, 4'h0, 2, 1, 32'h1357_9BDF, 1'b0);

`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
        // Subordinate grants but never answers in time.
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        @(negedge clk_i);
        apb_psel_i = 1'b1; apb_penable_i = 1'b0; apb_pwrite_i = 1'b0; apb_paddr_i = 32'h400;
        lat = 0;
        @(negedge clk_i);
        lat++;
        apb_penable_i = 1'b1; obi_gnt_i = 1'b1;
        @(negedge clk_i);
        lat++;
        obi_gnt_i = 1'b0;
        wait_ready("t6_timeout", lat);
        check("t6_timeout.latency", 64'(lat), 64'(2 + 255));
        compare_response("t6_timeout");
        @(negedge clk_i);
        apb_psel_i = 1'b0; apb_penable_i = 1'b0;
        // New setup while draining must stall.
        @(negedge clk_i);
        apb_psel_i = 1'b1; apb_paddr_i = 32'h800;
        @(negedge clk_i);
        apb_penable_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("t6_stall.req", 64'(obi_req_o), 64'd0);
            check("t6_stall.pready", 64'(apb_pready_o), 64'd0);
        end
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'h7777_7777;
        @(negedge clk_i);
        obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0;
        check("t6_late_rvalid.no_ready", 64'(apb_pready_o), 64'd0);
        for (int i = 0; i < 5 && obi_req_o !== 1'b1; i++) @(negedge clk_i);
        check("t6_resume.req", 64'(obi_req_o), 64'd1);
        check("t6_resume.addr", 64'(obi_addr_o), 64'h800);
        sb.push_back('{rdata: 32'h00C0_FFEE, err: 1'b0});
        obi_gnt_i = 1'b1;
        @(negedge clk_i);
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; obi_rdata_i = 32'h00C0_FFEE;
        @(negedge clk_i);
        obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0;
        lat = 0;
        wait_ready("t6_resume", lat);
        compare_response("t6_resume");
        @(negedge clk_i);
        apb_psel_i = 1'b0; apb_penable_i = 1'b0;
`endif

        check("sb.empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
